// File: rtl/shot_resolver_if.sv
// Cursor/button inputs and board/turn outputs shared between the resolver
// and the cursor controller, renderer and turn counter around it.
interface shot_resolver_if;
  logic         btn_c;
  logic [3:0]   sprite_row;
  logic [3:0]   sprite_col;
  logic [199:0] cell_status_flat;
  logic [4:0]   turns_left;
  logic         shot_pulse;
  logic         repeat_pulse;
  logic         game_won;
  logic         game_lost;

  modport master (
    output btn_c, sprite_row, sprite_col,
    input  cell_status_flat, turns_left, shot_pulse, repeat_pulse, game_won, game_lost
  );

  modport slave (
    input  btn_c, sprite_row, sprite_col,
    output cell_status_flat, turns_left, shot_pulse, repeat_pulse, game_won, game_lost
  );
endinterface

// File: rtl/shot_resolver.sv
// Battleship fire/turn engine: debounces the fire button, resolves each shot
// against a fixed ship map and tracks board status, remaining turns and win/lose.
module shot_resolver #(
  parameter int          DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [4:0]  TURNS_INIT      = 5'd20,
  parameter logic [99:0] SHIP_MAP        = 100'h00C00003800000E000780001F,
  parameter logic [6:0]  HITS_TO_WIN     = 7'd17
) (
  input logic             clk,
  input logic             reset,
  shot_resolver_if.slave  bus
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, CHECK, WON, LOST, CLEAR} state_t;

  logic          sync0, sync1, stable;
  logic [CW-1:0] db_cnt;
  logic          fire_req;

  state_t        state;
  logic [3:0]    row_q, col_q;
  logic [199:0]  cells;
  logic [4:0]    turns;
  logic [6:0]    hits;
  logic          shot_pulse_q, repeat_pulse_q, won_q, lost_q;

  logic [6:0]    idx;
  logic [1:0]    cur_status;
  logic          is_ship;
  logic [6:0]    hits_next;
  logic [4:0]    turns_next;

  // The counter only runs while the synced level disagrees with the stable
  // level, so any bounce back to the stable level restarts the wait.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync0    <= 1'b0;
      sync1    <= 1'b0;
      stable   <= 1'b0;
      db_cnt   <= '0;
      fire_req <= 1'b0;
    end else begin
      sync0    <= bus.btn_c;
      sync1    <= sync0;
      fire_req <= 1'b0;
      if (sync1 != stable) begin
        if (db_cnt == CNT_MAX) begin
          stable   <= sync1;
          db_cnt   <= '0;
          fire_req <= sync1;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign idx        = 7'(row_q) * 7'd10 + 7'(col_q);
  assign cur_status = cells[{idx, 1'b0} +: 2];
  assign is_ship    = SHIP_MAP[idx];
  assign hits_next  = hits + {6'd0, is_ship};
  assign turns_next = turns - 5'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      row_q          <= '0;
      col_q          <= '0;
      cells          <= '0;
      turns          <= TURNS_INIT;
      hits           <= '0;
      shot_pulse_q   <= 1'b0;
      repeat_pulse_q <= 1'b0;
      won_q          <= 1'b0;
      lost_q         <= 1'b0;
    end else begin
      shot_pulse_q   <= 1'b0;
      repeat_pulse_q <= 1'b0;
      case (state)
        IDLE: begin
          if (fire_req && bus.sprite_row < 4'd10 && bus.sprite_col < 4'd10) begin
            row_q <= bus.sprite_row;
            col_q <= bus.sprite_col;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (cur_status != 2'b00) begin
            repeat_pulse_q <= 1'b1;
            state          <= IDLE;
          end else begin
            cells[{idx, 1'b0} +: 2] <= is_ship ? 2'b10 : 2'b01;
            turns        <= turns_next;
            hits         <= hits_next;
            shot_pulse_q <= 1'b1;
            // A win on the final turn takes priority over running out of turns.
            if (hits_next == HITS_TO_WIN) begin
              state <= WON;
              won_q <= 1'b1;
            end else if (turns_next == 5'd0) begin
              state  <= LOST;
              lost_q <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        WON, LOST: begin
          if (fire_req) state <= CLEAR;
        end
        CLEAR: begin
          cells  <= '0;
          turns  <= TURNS_INIT;
          hits   <= '0;
          won_q  <= 1'b0;
          lost_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cell_status_flat = cells;
  assign bus.turns_left       = turns;
  assign bus.shot_pulse       = shot_pulse_q;
  assign bus.repeat_pulse     = repeat_pulse_q;
  assign bus.game_won         = won_q;
  assign bus.game_lost        = lost_q;

endmodule

// File: tb/tb_shot_resolver.sv
// Scoreboard bench for shot_resolver: three instances with different turn/win
// parameters, expected shot/repeat events queued by stimulus and popped by monitors.
module tb_shot_resolver;

  localparam logic [99:0] MAP = 100'h00C00003800000E000780001F;

  typedef struct {
    bit         is_shot;
    int         idx;
    logic [1:0] status;
    logic [4:0] turns;
    logic       won;
    logic       lost;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shot_resolver_if if_a ();
  shot_resolver_if if_b ();
  shot_resolver_if if_c ();

  shot_resolver #(.DEBOUNCE_CYCLES(4), .TURNS_INIT(5'd20), .SHIP_MAP(MAP), .HITS_TO_WIN(7'd17))
    dut_a (.clk(clk), .reset(reset), .bus(if_a));
  shot_resolver #(.DEBOUNCE_CYCLES(4), .TURNS_INIT(5'd3), .SHIP_MAP(MAP), .HITS_TO_WIN(7'd17))
    dut_b (.clk(clk), .reset(reset), .bus(if_b));
  shot_resolver #(.DEBOUNCE_CYCLES(4), .TURNS_INIT(5'd2), .SHIP_MAP(MAP), .HITS_TO_WIN(7'd2))
    dut_c (.clk(clk), .reset(reset), .bus(if_c));

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  exp_t ev_a, ev_b, ev_c;
  int   checks = 0;
  int   fails  = 0;
  int   shots_a = 0;
  logic [199:0] board_exp;

  task automatic checkVal(input string name, input logic [199:0] act, input logic [199:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic checkOutput(input string tag, input exp_t e, input logic shot, input logic rep,
                             input logic [199:0] cells, input logic [4:0] turns,
                             input logic won, input logic lost);
    checkVal({tag, "_shot_pulse"},   {199'd0, shot}, {199'd0, e.is_shot});
    checkVal({tag, "_repeat_pulse"}, {199'd0, rep},  {199'd0, !e.is_shot});
    checkVal({tag, "_cell_status"},  {198'd0, cells[2*e.idx +: 2]}, {198'd0, e.status});
    checkVal({tag, "_turns_left"},   {195'd0, turns}, {195'd0, e.turns});
    checkVal({tag, "_game_won"},     {199'd0, won},  {199'd0, e.won});
    checkVal({tag, "_game_lost"},    {199'd0, lost}, {199'd0, e.lost});
  endtask

  task automatic unexpectedPulse(input string tag);
    checks++;
    fails++;
    $display("[TB] FAIL %s_unexpected_pulse: got a strobe, expected none", tag);
  endtask

  // Monitors: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (if_a.shot_pulse || if_a.repeat_pulse) begin
      if (if_a.shot_pulse) shots_a++;
      if (q_a.size() == 0) unexpectedPulse("a");
      else begin
        ev_a = q_a.pop_front();
        checkOutput("a", ev_a, if_a.shot_pulse, if_a.repeat_pulse, if_a.cell_status_flat,
                    if_a.turns_left, if_a.game_won, if_a.game_lost);
      end
    end
  end

  always @(negedge clk) begin
    if (if_b.shot_pulse || if_b.repeat_pulse) begin
      if (q_b.size() == 0) unexpectedPulse("b");
      else begin
        ev_b = q_b.pop_front();
        checkOutput("b", ev_b, if_b.shot_pulse, if_b.repeat_pulse, if_b.cell_status_flat,
                    if_b.turns_left, if_b.game_won, if_b.game_lost);
      end
    end
  end

  always @(negedge clk) begin
    if (if_c.shot_pulse || if_c.repeat_pulse) begin
      if (q_c.size() == 0) unexpectedPulse("c");
      else begin
        ev_c = q_c.pop_front();
        checkOutput("c", ev_c, if_c.shot_pulse, if_c.repeat_pulse, if_c.cell_status_flat,
                    if_c.turns_left, if_c.game_won, if_c.game_lost);
      end
    end
  end

  function automatic exp_t mk(input bit s, input int i, input logic [1:0] st,
                              input logic [4:0] t, input logic w, input logic l);
    exp_t e;
    e.is_shot = s; e.idx = i; e.status = st; e.turns = t; e.won = w; e.lost = l;
    return e;
  endfunction

  task automatic driveBtn(input int sel, input logic v);
    case (sel)
      0: if_a.btn_c = v;
      1: if_b.btn_c = v;
      default: if_c.btn_c = v;
    endcase
  endtask

  task automatic driveCell(input int sel, input logic [3:0] r, input logic [3:0] c);
    case (sel)
      0: begin if_a.sprite_row = r; if_a.sprite_col = c; end
      1: begin if_b.sprite_row = r; if_b.sprite_col = c; end
      default: begin if_c.sprite_row = r; if_c.sprite_col = c; end
    endcase
  endtask

  function automatic int qSize(input int sel);
    case (sel)
      0: return q_a.size();
      1: return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  task automatic applyStimulus(input int sel, input logic [3:0] r, input logic [3:0] c, input int hold);
    @(negedge clk);
    driveCell(sel, r, c);
    driveBtn(sel, 1'b1);
    repeat (hold) @(negedge clk);
    driveBtn(sel, 1'b0);
    repeat (12) @(negedge clk);
  endtask

  task automatic waitDrain(input int sel);
    int n;
    for (n = 0; n < 60 && qSize(sel) != 0; n++) @(negedge clk);
    if (qSize(sel) != 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL drain_timeout_%0d: %0d events pending, expected 0", sel, qSize(sel));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    for (int s = 0; s < 3; s++) begin
      driveBtn(s, 1'b0);
      driveCell(s, 4'd0, 4'd0);
    end
    repeat (3) @(negedge clk);

    checkVal("reset_turns_a", {195'd0, if_a.turns_left}, 200'd20);
    checkVal("reset_board_a", if_a.cell_status_flat, 200'd0);
    checkVal("reset_flags_a", {196'd0, if_a.game_won, if_a.game_lost, if_a.shot_pulse, if_a.repeat_pulse}, 200'd0);
    checkVal("reset_turns_b", {195'd0, if_b.turns_left}, 200'd3);
    checkVal("reset_turns_c", {195'd0, if_c.turns_left}, 200'd2);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Cell (2,3) = index 23 is part of the four-cell ship.
    q_a.push_back(mk(1, 23, 2'b10, 5'd19, 1'b0, 1'b0));
    applyStimulus(0, 4'd2, 4'd3, 100);
    waitDrain(0);
    checkVal("held_press_single_shot", 200'(shots_a), 200'd1);

    q_a.push_back(mk(0, 23, 2'b10, 5'd19, 1'b0, 1'b0));
    applyStimulus(0, 4'd2, 4'd3, 12);
    waitDrain(0);

    board_exp = '0;
    board_exp[47:46] = 2'b10;
    @(negedge clk);
    driveBtn(0, 1'b1);
    repeat (2) @(negedge clk);
    driveBtn(0, 1'b0);
    repeat (20) @(negedge clk);
    checkVal("glitch_turns", {195'd0, if_a.turns_left}, 200'd19);
    checkVal("glitch_board", if_a.cell_status_flat, board_exp);

    applyStimulus(0, 4'd12, 4'd3, 12);
    repeat (10) @(negedge clk);
    checkVal("out_of_range_turns", {195'd0, if_a.turns_left}, 200'd19);
    checkVal("out_of_range_board", if_a.cell_status_flat, board_exp);

    // Row 5 holds no ships, so three shots there exhaust instance b.
    q_b.push_back(mk(1, 55, 2'b01, 5'd2, 1'b0, 1'b0));
    q_b.push_back(mk(1, 56, 2'b01, 5'd1, 1'b0, 1'b0));
    q_b.push_back(mk(1, 57, 2'b01, 5'd0, 1'b0, 1'b1));
    applyStimulus(1, 4'd5, 4'd5, 12);
    applyStimulus(1, 4'd5, 4'd6, 12);
    applyStimulus(1, 4'd5, 4'd7, 12);
    waitDrain(1);
    checkVal("lost_level", {199'd0, if_b.game_lost}, 200'd1);
    applyStimulus(1, 4'd0, 4'd0, 12);
    checkVal("clear_board_b", if_b.cell_status_flat, 200'd0);
    checkVal("clear_turns_b", {195'd0, if_b.turns_left}, 200'd3);
    checkVal("clear_lost_b", {199'd0, if_b.game_lost}, 200'd0);

    q_c.push_back(mk(1, 0, 2'b10, 5'd1, 1'b0, 1'b0));
    q_c.push_back(mk(1, 1, 2'b10, 5'd0, 1'b1, 1'b0));
    applyStimulus(2, 4'd0, 4'd0, 12);
    applyStimulus(2, 4'd0, 4'd1, 12);
    waitDrain(2);
    checkVal("won_level", {198'd0, if_c.game_won, if_c.game_lost}, 200'd2);
    applyStimulus(2, 4'd0, 4'd0, 12);
    checkVal("clear_turns_c", {195'd0, if_c.turns_left}, 200'd2);
    checkVal("clear_won_c", {199'd0, if_c.game_won}, 200'd0);

    q_c.push_back(mk(1, 50, 2'b01, 5'd1, 1'b0, 1'b0));
    applyStimulus(2, 4'd5, 4'd0, 12);
    waitDrain(2);

    // Debounce plus IDLE->CHECK takes seven edges from the press.
    @(negedge clk);
    driveCell(2, 4'd0, 4'd0);
    driveBtn(2, 1'b1);
    repeat (7) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkVal("abort_turns_c", {195'd0, if_c.turns_left}, 200'd2);
    checkVal("abort_board_c", if_c.cell_status_flat, 200'd0);
    checkVal("abort_flags_c", {196'd0, if_c.game_won, if_c.game_lost, if_c.shot_pulse, if_c.repeat_pulse}, 200'd0);
    checkVal("abort_turns_a", {195'd0, if_a.turns_left}, 200'd20);
    checkVal("abort_board_a", if_a.cell_status_flat, 200'd0);
    driveBtn(2, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    checkVal("post_abort_turns_c", {195'd0, if_c.turns_left}, 200'd2);

    checkVal("queue_a_empty", 200'(q_a.size()), 200'd0);
    checkVal("queue_b_empty", 200'(q_b.size()), 200'd0);
    checkVal("queue_c_empty", 200'(q_c.size()), 200'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
